// File: rtl/frs_message_transmitter.sv
// FRS Message source: queues function-readiness events and issues each one as a
// message request to the TL transmit arbiter, with a forced idle gap between messages.
module frs_message_transmitter #(
  parameter int QUEUE_DEPTH = 4,
  parameter int MIN_GAP     = 8,
  parameter int FUNC_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           link_dl_down,
  input  logic                           frs_tx_enable,
  input  logic                           evt_valid,
  input  logic [FUNC_W-1:0]              evt_func,
  input  logic [3:0]                     evt_reason,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [7:0]                     tx_msg_code,
  output logic [FUNC_W-1:0]              tx_func,
  output logic [3:0]                     tx_reason,
  output logic                           evt_dropped,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam logic [7:0] FRS_MSG_CODE = 8'h09;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                state;
  logic [FUNC_W+3:0]     mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [GAP_W-1:0]      gap_cnt;
  logic [FUNC_W+3:0]     head;
  logic                  pop;
  logic                  push;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push then.
  assign pop  = (state == IDLE) && (count != '0) && !link_dl_down;
  assign push = evt_valid && frs_tx_enable && !link_dl_down &&
                ((count < CNT_W'(QUEUE_DEPTH)) || pop);
  assign head = mem[rd_ptr];
  assign queue_count = count;

  // NOTE: storage has no reset; validity is tracked by count, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {evt_func, evt_reason};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      gap_cnt     <= '0;
      tx_valid    <= 1'b0;
      tx_msg_code <= '0;
      tx_func     <= '0;
      tx_reason   <= '0;
      evt_dropped <= 1'b0;
    end else begin
      evt_dropped <= evt_valid && !push;
      if (link_dl_down) begin
        state       <= IDLE;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        gap_cnt     <= '0;
        tx_valid    <= 1'b0;
        tx_msg_code <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase

        case (state)
          IDLE: begin
            if (pop) begin
              {tx_func, tx_reason} <= head;
              tx_valid             <= 1'b1;
              tx_msg_code          <= FRS_MSG_CODE;
              state                <= SEND;
            end
          end
          SEND: begin
            if (tx_ready) begin
              tx_valid    <= 1'b0;
              tx_msg_code <= '0;
              gap_cnt     <= GAP_W'(MIN_GAP);
              state       <= GAP;
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt - GAP_W'(1);
            if (gap_cnt == GAP_W'(1)) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frs_message_transmitter.sv
// Directed bench for frs_message_transmitter: stimulus pushes expected messages into a
// scoreboard queue, a negedge monitor pops and compares on every accepted request.
module tb_frs_message_transmitter;

  localparam int QUEUE_DEPTH = 4;
  localparam int MIN_GAP     = 8;
  localparam int FUNC_W      = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              link_dl_down = 1'b0;
  logic              frs_tx_enable = 1'b0;
  logic              evt_valid = 1'b0;
  logic [FUNC_W-1:0] evt_func = '0;
  logic [3:0]        evt_reason = '0;
  logic              tx_ready = 1'b0;
  logic              tx_valid;
  logic [7:0]        tx_msg_code;
  logic [FUNC_W-1:0] tx_func;
  logic [3:0]        tx_reason;
  logic              evt_dropped;
  logic [2:0]        queue_count;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int accepts    = 0;
  int drops_seen = 0;
  int last_acc   = 0;
  bit gap_armed  = 1'b0;
  logic [11:0] sb [$];

  frs_message_transmitter #(
    .QUEUE_DEPTH(QUEUE_DEPTH),
    .MIN_GAP    (MIN_GAP),
    .FUNC_W     (FUNC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .link_dl_down (link_dl_down),
    .frs_tx_enable(frs_tx_enable),
    .evt_valid    (evt_valid),
    .evt_func     (evt_func),
    .evt_reason   (evt_reason),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_msg_code  (tx_msg_code),
    .tx_func      (tx_func),
    .tx_reason    (tx_reason),
    .evt_dropped  (evt_dropped),
    .queue_count  (queue_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, so an accept seen here lands on the next rising edge.
  initial begin
    logic        prev_hold;
    logic        prev_flush;
    logic [11:0] prev_fields;
    prev_hold   = 1'b0;
    prev_flush  = 1'b0;
    prev_fields = '0;
    forever begin
      @(negedge clk);
      if (evt_dropped) drops_seen++;
      if (prev_hold && !prev_flush) begin
        check("valid_held", 32'(tx_valid), 32'd1);
        check("fields_stable", 32'({tx_func, tx_reason}), 32'(prev_fields));
      end
      if (tx_valid) check("msg_code", 32'(tx_msg_code), 32'h09);
      if (tx_valid && tx_ready && !rst && !link_dl_down) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_msg: got func=0x%0h reason=0x%0h, expected no message",
                   tx_func, tx_reason);
        end else begin
          check("msg_fields", 32'({tx_func, tx_reason}), 32'(sb.pop_front()));
        end
        if (gap_armed) check("accept_gap", 32'((cyc + 1 - last_acc) >= MIN_GAP + 2), 32'd1);
        last_acc  = cyc + 1;
        gap_armed = 1'b1;
        accepts++;
      end
      prev_hold   = tx_valid && !tx_ready;
      prev_flush  = rst || link_dl_down;
      prev_fields = {tx_func, tx_reason};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a one-cycle event; the push (or drop) happens on the next rising edge.
  task automatic send_evt(input logic [7:0] f, input logic [3:0] r, input bit expect_msg);
    evt_valid  = 1'b1;
    evt_func   = f;
    evt_reason = r;
    if (expect_msg) sb.push_back({f, r});
    tick();
    evt_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((sb.size() != 0 || tx_valid) && n < limit) begin
      tick();
      n++;
    end
    check("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int acc_edge;
    int acc_before;

    // Reset state
    tick();
    tick();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_msg_code", 32'(tx_msg_code), 32'd0);
    check("rst_count", 32'(queue_count), 32'd0);
    check("rst_dropped", 32'(evt_dropped), 32'd0);
    rst = 1'b0;
    frs_tx_enable = 1'b1;
    tick();

    // Single event: one cycle in FIFO, tx_valid for exactly one cycle with ready high
    tx_ready = 1'b1;
    send_evt(8'd3, 4'h1, 1'b1);
    check("single_in_fifo", 32'(queue_count), 32'd1);
    check("single_not_yet", 32'(tx_valid), 32'd0);
    tick();
    check("single_valid", 32'(tx_valid), 32'd1);
    check("single_func", 32'(tx_func), 32'd3);
    check("single_reason", 32'(tx_reason), 32'd1);
    check("single_popped", 32'(queue_count), 32'd0);
    tick();
    check("single_one_cycle", 32'(tx_valid), 32'd0);
    repeat (12) tick();

    // Three back-to-back events drain in order, spaced by the gap
    send_evt(8'h21, 4'h2, 1'b1);
    send_evt(8'h22, 4'h3, 1'b1);
    send_evt(8'h23, 4'h4, 1'b1);
    drain(100);
    check("burst_accepts", 32'(accepts), 32'd4);
    repeat (12) tick();

    // Overfill with ready low: head in output reg, four queued, last dropped
    tx_ready = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH + 2; i++)
      send_evt(8'(10 + i), 4'(i + 5), i < QUEUE_DEPTH + 1);
    check("full_count", 32'(queue_count), 32'd4);
    check("full_drop_pulse", 32'(evt_dropped), 32'd1);
    check("full_head_valid", 32'(tx_valid), 32'd1);
    check("full_head_func", 32'(tx_func), 32'd10);
    tick();
    check("full_drop_single", 32'(evt_dropped), 32'd0);

    // Stall for 20 cycles; the monitor checks field stability every cycle
    repeat (20) tick();
    check("stall_func", 32'(tx_func), 32'd10);
    check("stall_reason", 32'(tx_reason), 32'd5);

    // Release ready; push into the full FIFO on the exact cycle of the next pop
    tx_ready = 1'b1;
    acc_edge = cyc + 1;
    while (cyc < acc_edge + MIN_GAP) tick();
    send_evt(8'h40, 4'hA, 1'b1);
    check("pushpop_count", 32'(queue_count), 32'd4);
    check("pushpop_no_drop", 32'(evt_dropped), 32'd0);
    check("pushpop_valid", 32'(tx_valid), 32'd1);
    check("pushpop_func", 32'(tx_func), 32'd11);
    drain(150);
    repeat (12) tick();

    // DL_Down with two queued and one in flight: everything flushed, events dropped
    tx_ready = 1'b0;
    send_evt(8'h31, 4'h1, 1'b0);
    send_evt(8'h32, 4'h2, 1'b0);
    send_evt(8'h33, 4'h3, 1'b0);
    check("dl_pre_count", 32'(queue_count), 32'd2);
    check("dl_pre_valid", 32'(tx_valid), 32'd1);
    acc_before = accepts;
    link_dl_down = 1'b1;
    send_evt(8'h34, 4'h4, 1'b0);
    check("dl_valid", 32'(tx_valid), 32'd0);
    check("dl_count", 32'(queue_count), 32'd0);
    check("dl_msg_code", 32'(tx_msg_code), 32'd0);
    check("dl_drop", 32'(evt_dropped), 32'd1);
    send_evt(8'h35, 4'h5, 1'b0);
    check("dl_drop_again", 32'(evt_dropped), 32'd1);
    link_dl_down = 1'b0;
    gap_armed = 1'b0;
    tx_ready = 1'b1;
    repeat (15) tick();
    check("dl_no_resend", 32'(accepts), 32'(acc_before));

    // Transmission disabled: event dropped, nothing queued
    frs_tx_enable = 1'b0;
    send_evt(8'h50, 4'h6, 1'b0);
    check("dis_drop", 32'(evt_dropped), 32'd1);
    check("dis_count", 32'(queue_count), 32'd0);
    frs_tx_enable = 1'b1;
    tick();

    // Reset mid-transfer clears everything including the drop pulse
    tx_ready = 1'b0;
    send_evt(8'h61, 4'h1, 1'b0);
    send_evt(8'h62, 4'h2, 1'b0);
    rst = 1'b1;
    send_evt(8'h63, 4'h3, 1'b0);
    check("rst_mid_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_count", 32'(queue_count), 32'd0);
    check("rst_mid_dropped", 32'(evt_dropped), 32'd0);
    check("rst_mid_msg_code", 32'(tx_msg_code), 32'd0);
    rst = 1'b0;
    gap_armed = 1'b0;
    tx_ready = 1'b1;
    tick();
    send_evt(8'h07, 4'h5, 1'b1);
    drain(40);
    repeat (3) tick();
    check("drop_total", 32'(drops_seen), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
